// File: rtl/qspi_rr_arbiter.sv
// qspi_rr_arbiter: round-robin owner selection for the shared QSPI mux.
// Enforces a chip-select idle gap between owners and, optionally, a maximum
// tenure after which the grant is revoked and the owner is locked out until
// it drops its request.
module qspi_rr_arbiter #(
   parameter int N          = 4,
   parameter int GAP_CYCLES = 2,
   parameter int MAX_TENURE = 0,
   parameter int TW         = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N-1:0]           request,
   output logic [N-1:0]           grant,
   output logic [$clog2(N)-1:0]   mux_sel,
   output logic                   mux_valid,
   output logic                   timeout,
   output logic [$clog2(N)-1:0]   timeout_id
);

   localparam int LW = $clog2(N);
   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [TW-1:0] TEN_LIM = TW'(MAX_TENURE - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, OWNED = 2'd1, GAP = 2'd2} state_t;

   state_t          state_r, state_n;
   logic [LW-1:0]   owner_r, owner_n;
   logic [LW-1:0]   last_r, last_n;
   logic [TW-1:0]   tenure_r, tenure_n;
   logic [GW-1:0]   gap_r, gap_n;
   logic [N-1:0]    lockout_r, lockout_n;
   logic [N-1:0]    grant_n;
   logic [LW-1:0]   sel_n;
   logic            valid_n;
   logic            timeout_n;
   logic [LW-1:0]   tid_n;
   logic            release_s, revoke_s, arb_s;
   logic [N-1:0]    excl_s, elig_s;
   logic [LW:0]     pick_s;

   // One-hot vector for an index.
   function automatic logic [N-1:0] onehot(input logic [LW-1:0] idx);
      logic [N-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // First eligible index searching from (from+1) mod N with wrap; MSB = found.
   function automatic logic [LW:0] rr_pick(input logic [N-1:0] elig, input logic [LW-1:0] from);
      logic [LW:0] res;
      int          idx;
      res = '0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(from) + k) % N;
         if (!res[LW] && elig[idx]) begin
            res = {1'b1, LW'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Next-state, arbitration, watchdog and lockout bookkeeping.
   always_comb begin
      state_n   = state_r;
      owner_n   = owner_r;
      last_n    = last_r;
      tenure_n  = tenure_r;
      gap_n     = gap_r;
      grant_n   = grant;
      timeout_n = 1'b0;
      tid_n     = timeout_id;
      lockout_n = lockout_r & request;
      arb_s     = 1'b0;
      release_s = ~request[owner_r];
      revoke_s  = (MAX_TENURE != 0) && request[owner_r] && (tenure_r == TEN_LIM);
      // A revoked owner must not win the same-edge handoff.
      if (state_r == OWNED && revoke_s) begin
         excl_s = onehot(owner_r);
      end else begin
         excl_s = '0;
      end
      elig_s = request & ~lockout_r & ~excl_s;
      pick_s = rr_pick(elig_s, last_r);

      case (state_r)
         IDLE: begin
            arb_s = 1'b1;
         end
         OWNED: begin
            if (release_s || revoke_s) begin
               grant_n = '0;
               if (!release_s) begin
                  timeout_n          = 1'b1;
                  tid_n              = owner_r;
                  lockout_n[owner_r] = 1'b1;
               end else begin
                  timeout_n = 1'b0;
               end
               if (GAP_CYCLES == 0) begin
                  arb_s = 1'b1;
               end else begin
                  gap_n   = GAP_LOAD;
                  state_n = GAP;
               end
            end else if (tenure_r != {TW{1'b1}}) begin
               tenure_n = tenure_r + TW'(1);
            end else begin
               tenure_n = tenure_r;
            end
         end
         GAP: begin
            if (gap_r == GW'(0)) begin
               arb_s = 1'b1;
            end else begin
               gap_n = gap_r - GW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase

      if (arb_s) begin
         if (pick_s[LW]) begin
            owner_n  = pick_s[LW-1:0];
            last_n   = pick_s[LW-1:0];
            grant_n  = onehot(pick_s[LW-1:0]);
            tenure_n = '0;
            state_n  = OWNED;
         end else begin
            grant_n = '0;
            state_n = IDLE;
         end
      end else begin
         arb_s = 1'b0;
      end

      valid_n = |grant_n;
      if (valid_n) begin
         sel_n = owner_n;
      end else begin
         sel_n = '0;
      end
   end

   // State and registered outputs; asynchronous clear to the post-reset priority.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= IDLE;
         owner_r    <= '0;
         last_r     <= LW'(N - 1);
         tenure_r   <= '0;
         gap_r      <= '0;
         lockout_r  <= '0;
         grant      <= '0;
         mux_sel    <= '0;
         mux_valid  <= 1'b0;
         timeout    <= 1'b0;
         timeout_id <= '0;
      end else begin
         state_r    <= state_n;
         owner_r    <= owner_n;
         last_r     <= last_n;
         tenure_r   <= tenure_n;
         gap_r      <= gap_n;
         lockout_r  <= lockout_n;
         grant      <= grant_n;
         mux_sel    <= sel_n;
         mux_valid  <= valid_n;
         timeout    <= timeout_n;
         timeout_id <= tid_n;
      end
   end

endmodule

// File: doc/qspi_rr_arbiter.md
# qspi_rr_arbiter

Round-robin arbiter that shares the QSPI mux output among up to N requesters. It replaces fixed-priority grant selection with fair rotation and enforces a programmable chip-select idle gap between owners. An optional maximum-tenure watchdog revokes a grant from a requester that holds the bus too long. It drives the mux select and per-requester grant lines; requesters follow the request → wait-for-grant → transact → drop-request protocol.

## Interface
- `N`, default 4: number of requesters (2..8).
- `GAP_CYCLES`, default 2: minimum grant-low cycles between consecutive owners. 0 allows direct handoff.
- `MAX_TENURE`, default 0: maximum consecutive grant cycles per tenure. 0 disables the watchdog.
- `TW`, default 16: width of the tenure counter; `MAX_TENURE` < 2^TW.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `request`  in  N  request[i] high = requester i wants the mux; held until done.
- `grant`  out  N  registered, one-hot or zero; grant[i] = requester i owns the mux.
- `mux_sel`  out  $clog2(N)  index of current owner; 0 when no grant.
- `mux_valid`  out  1  high iff any grant bit is high.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- `timeout_id`  out  $clog2(N)  index revoked by the last timeout; holds until the next timeout.

## Operation
- States: IDLE, OWNED, GAP.
- Eligible requester: request[i] = 1 and lockout[i] = 0.
- Arbitration searches eligible requesters starting at (last+1) mod N and wrapping; the first hit wins. `last` is the most recently granted index.
- IDLE: with any eligible request, latch the winner as owner, set grant[owner], load last = owner, clear the tenure counter, go to OWNED. Otherwise stay in IDLE.
- OWNED, request[owner] sampled low (release): clear grant.
  - If GAP_CYCLES = 0, arbitrate at the same edge. The grant may switch directly to a new owner, or go to IDLE if none is eligible.
  - Otherwise load gap_cnt = GAP_CYCLES-1 and go to GAP.
- OWNED, request[owner] still high, MAX_TENURE ≠ 0, tenure = MAX_TENURE-1 (revoke): clear grant, pulse timeout, set timeout_id = owner, set lockout[owner]. Then proceed as for a release (GAP, or immediate arbitration if GAP_CYCLES = 0).
- OWNED, otherwise: increment tenure; saturates at 2^TW-1.
- Release and revoke conditions true at the same edge: release wins. No timeout pulse, no lockout.
- GAP: if gap_cnt = 0, arbitrate as in IDLE (grant, or go to IDLE if nothing is eligible). Otherwise decrement gap_cnt.
- Lockout: lockout[i] clears at any edge where request[i] is sampled low. A revoked requester must drop its request before it can be granted again.
- mux_sel and mux_valid are registered alongside grant and always consistent with it.
- Reset (asynchronous, any state):
  - grant = 0, mux_sel = 0, mux_valid = 0, timeout = 0, timeout_id = 0.
  - state = IDLE, last = N-1 (requester 0 has first priority after reset), lockout = 0, counters = 0.
  - Outputs clear immediately on resetn falling. The first arbitration occurs at the first rising edge with resetn high.

## Timing
- Grant latency: request sampled at edge k in IDLE → grant high from edge k to edge k+1 onward. This is 1 cycle.
- Release: request drop sampled at edge k → grant low after edge k.
- Gap: with a pending eligible request, grant stays low for exactly GAP_CYCLES cycles. The next grant rises at edge k+GAP_CYCLES.
- Watchdog: grant stays high for exactly MAX_TENURE cycles when request is never dropped. The timeout pulse coincides with the first grant-low cycle.
- Never more than one grant bit is high in any cycle. With GAP_CYCLES ≥ 1, an all-zero cycle always separates two owners.

## Test plan
- Reset then single requester: N=4, GAP=2, request = 0100 at edge 1 → grant = 0100, mux_sel = 2 from edge 2. Drop at edge 10 → grant = 0 after edge 10.
- Round-robin fairness: requesters 0–3 held high continuously, each releasing after 5 granted cycles → grant order 0,1,2,3,0. Each owner change is separated by exactly 2 zero cycles.
- Gap=0 handoff: GAP=0, requesters 1 and 2 high, 1 releases at edge k → grant goes 0010 → 0100 at edge k with no zero cycle.
- Watchdog: MAX_TENURE=8, requester 3 holds its request → grant high 8 cycles, then a 1-cycle timeout pulse with timeout_id = 3. Requester 3 is not re-granted while its request stays high. After it drops and re-raises, it is granted again.
- Simultaneous release/timeout: request drops on the edge where tenure = MAX_TENURE-1 → no timeout pulse, no lockout.
- Async reset mid-tenure: assert resetn low while grant = 0010 → grant, mux_sel and mux_valid go 0 without waiting for a clock edge. After release, request = 1111 → requester 0 is granted first.
